// File: rtl/aes_128_sched.sv
// Front-end controller for aes_128_top: round-key loading, two-way round-robin
// block issue with bounded in-flight tracking, and in-order result routing.
module aes_128_sched #(
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned ISSUE_GAP    = 1
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         key_load_start,
  output logic [3:0]   key_rd_addr,
  input  logic [127:0] key_rd_data,
  output logic         key_valid,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         en_wr,
  output logic [127:0] key_round_wr,
  output logic         core_in_en,
  output logic [127:0] core_in_data,
  input  logic         core_out_en,
  input  logic [127:0] core_out_data,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         busy,
  output logic         err_pulse
);

  localparam int unsigned AW = $clog2(MAX_INFLIGHT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [3:0] LAST_ADDR = 4'd10;
  localparam logic [3:0] LAST_STEP = 4'd11;

  typedef enum logic [1:0] {NOKEY, LOAD, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [3:0]              step;
  logic [CW-1:0]           inflight;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [MAX_INFLIGHT-1:0] tags;
  logic                    last_id;
  logic [GW-1:0]           gap;
  logic                    eligible, grant0, grant1, xfer, pop;

  assign eligible = ~kill && (state == RUN) && (inflight < CW'(MAX_INFLIGHT)) && (gap == '0);
  // On a tie the requester that did not win last time is granted.
  assign grant0 = eligible && req0_valid && (!req1_valid || last_id);
  assign grant1 = eligible && req1_valid && (!req0_valid || !last_id);
  assign xfer   = grant0 | grant1;
  assign pop    = core_out_en && (inflight != '0);

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign key_rd_addr  = (!kill && state == LOAD && step <= LAST_ADDR) ? step : 4'd0;
  assign en_wr        = !kill && (state == LOAD) && (step != 4'd0);
  assign key_round_wr = en_wr ? key_rd_data : '0;
  assign key_valid    = !kill && (state == RUN || state == DRAIN);
  assign busy         = !kill && (state != RUN || inflight != '0);

  always_ff @(posedge clk) begin
    if (kill) state <= NOKEY;
    else      state <= state_next;
  end

  // A transfer in the same cycle as the reload request still has to drain.
  always_comb begin
    state_next = state;
    case (state)
      NOKEY: if (key_load_start) state_next = LOAD;
      LOAD:  if (step == LAST_STEP) state_next = RUN;
      RUN:   if (key_load_start) state_next = (inflight != '0 || xfer) ? DRAIN : LOAD;
      DRAIN: if (inflight == '0) state_next = LOAD;
      default: state_next = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill || state != LOAD || state_next != LOAD) step <= 4'd0;
    else                                             step <= step + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (xfer) tags[wr_ptr] <= grant1;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      inflight     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_id      <= 1'b1;
      gap          <= '0;
      core_in_en   <= 1'b0;
      core_in_data <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      err_pulse    <= 1'b0;
    end else begin
      core_in_en <= xfer;
      if (xfer) begin
        core_in_data <= grant1 ? req1_data : req0_data;
        wr_ptr       <= wr_ptr + 1'b1;
        last_id      <= grant1;
        gap          <= GW'(ISSUE_GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rsp_id   <= tags[rd_ptr];
        rsp_data <= core_out_data;
      end
      inflight  <= inflight + CW'(xfer) - CW'(pop);
      rsp_valid <= pop;
      err_pulse <= core_out_en && !pop;
    end
  end

endmodule

// File: tb/tb_aes_128_sched.sv
// Randomized self-checking bench for aes_128_sched with a cycle-level
// reference model built on queues for tags and core results.
module tb_aes_128_sched;

  localparam int unsigned MAXF = 16;
  localparam int unsigned GAP  = 1;
  localparam int MD_NOKEY = 0, MD_LOAD = 1, MD_RUN = 2, MD_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         kill = 1'b1;
  logic         key_load_start = 1'b0;
  logic [3:0]   key_rd_addr;
  logic [127:0] key_rd_data = '0;
  logic         key_valid;
  logic         req0_valid = 1'b0;
  logic [127:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [127:0] req1_data = '0;
  logic         req1_ready;
  logic         en_wr;
  logic [127:0] key_round_wr;
  logic         core_in_en;
  logic [127:0] core_in_data;
  logic         core_out_en = 1'b0;
  logic [127:0] core_out_data = '0;
  logic         rsp_valid;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic         busy;
  logic         err_pulse;

  aes_128_sched #(.MAX_INFLIGHT(MAXF), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .kill(kill), .key_load_start(key_load_start),
    .key_rd_addr(key_rd_addr), .key_rd_data(key_rd_data), .key_valid(key_valid),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .en_wr(en_wr), .key_round_wr(key_round_wr),
    .core_in_en(core_in_en), .core_in_data(core_in_data),
    .core_out_en(core_out_en), .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .err_pulse(err_pulse)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] keys [16];
  logic [127:0] core_pend [$];
  int unsigned rel_pct = 0;
  logic [3:0] seen_addr = '0;

  int m_mode, m_step, m_gap;
  bit m_last;
  bit m_tags [$];
  bit m_iss_v, m_rsp_v, m_rsp_id, m_err;
  logic [127:0] m_iss_d, m_rsp_d;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] core_fn(input logic [127:0] x);
    return {x[63:0], x[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic model_reset();
    m_mode = MD_NOKEY; m_step = 0; m_gap = 0; m_last = 1'b1;
    m_tags.delete();
    m_iss_v = 0; m_iss_d = '0;
    m_rsp_v = 0; m_rsp_id = 0; m_rsp_d = '0; m_err = 0;
  endtask

  // One clock: compare at negedge against the model, advance the model, then
  // present memory/core responses just after the next posedge.
  task automatic cycle();
    int pick, sz;
    bit live;
    logic [3:0] e_addr;
    @(negedge clk);
    live = !kill;
    pick = -1;
    if (live && m_mode == MD_RUN && m_tags.size() < MAXF && m_gap == 0) begin
      if (req0_valid && req1_valid) pick = m_last ? 0 : 1;
      else if (req0_valid)          pick = 0;
      else if (req1_valid)          pick = 1;
    end
    e_addr = (live && m_mode == MD_LOAD && m_step <= 10) ? 4'(m_step) : 4'd0;
    check("req0_ready", req0_ready, pick == 0);
    check("req1_ready", req1_ready, pick == 1);
    check("key_rd_addr", key_rd_addr, e_addr);
    check("en_wr", en_wr, live && m_mode == MD_LOAD && m_step >= 1);
    if (live && m_mode == MD_LOAD && m_step >= 1)
      check("key_round_wr", key_round_wr, keys[m_step-1]);
    check("key_valid", key_valid, live && (m_mode == MD_RUN || m_mode == MD_DRAIN));
    check("busy", busy, live && (m_mode != MD_RUN || m_tags.size() != 0));
    check("core_in_en", core_in_en, m_iss_v);
    if (m_iss_v) check("core_in_data", core_in_data, m_iss_d);
    check("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v) begin
      check("rsp_id", rsp_id, m_rsp_id);
      check("rsp_data", rsp_data, m_rsp_d);
    end
    check("err_pulse", err_pulse, m_err);

    if (m_iss_v) core_pend.push_back(core_fn(m_iss_d));
    seen_addr = key_rd_addr;

    if (kill) begin
      model_reset();
    end else begin
      sz = m_tags.size();
      case (m_mode)
        MD_NOKEY: if (key_load_start) begin m_mode = MD_LOAD; m_step = 0; end
        MD_LOAD:  if (m_step == 11) m_mode = MD_RUN; else m_step++;
        MD_RUN:   if (key_load_start) begin
                    if (sz != 0 || pick >= 0) m_mode = MD_DRAIN;
                    else begin m_mode = MD_LOAD; m_step = 0; end
                  end
        default:  if (sz == 0) begin m_mode = MD_LOAD; m_step = 0; end
      endcase
      m_iss_v = (pick >= 0);
      if (pick >= 0) m_iss_d = (pick == 1) ? req1_data : req0_data;
      m_rsp_v = 0; m_err = 0;
      if (core_out_en) begin
        if (sz > 0) begin
          m_rsp_v = 1; m_rsp_id = m_tags.pop_front(); m_rsp_d = core_out_data;
        end else begin
          m_err = 1;
        end
      end
      if (pick >= 0) begin
        m_tags.push_back(pick == 1); m_last = (pick == 1); m_gap = GAP - 1;
      end else if (m_gap > 0) begin
        m_gap--;
      end
    end

    @(posedge clk); #1;
    key_rd_data = keys[seen_addr];
    key_load_start = 1'b0;
    core_out_en = 1'b0;
    if (rel_pct > 0 && core_pend.size() > 0 && $urandom_range(99) < rel_pct) begin
      core_out_en = 1'b1;
      core_out_data = core_pend.pop_front();
    end
  endtask

  task automatic pulse_load();
    if (m_mode != MD_LOAD)
      for (int r = 0; r < 16; r++) keys[r] = rnd128();
    key_load_start = 1'b1;
  endtask

  task automatic release_one();
    if (core_pend.size() > 0) begin
      core_out_en = 1'b1;
      core_out_data = core_pend.pop_front();
    end
  endtask

  task automatic drain_all();
    req0_valid = 1'b0; req1_valid = 1'b0; rel_pct = 100;
    for (int i = 0; i < 80; i++) begin
      if (m_tags.size() == 0 && core_pend.size() == 0 && !core_out_en) break;
      cycle();
    end
    cycle(); cycle();
    check("drain_busy", busy, 1'b0);
    rel_pct = 0;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) keys[r] = {16{8'(r)}};
    model_reset();
    kill = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    repeat (30) cycle();
    kill = 1'b0;

    // initial key load with the round-number pattern
    key_load_start = 1'b1;
    repeat (15) cycle();

    // single requester, fixed block
    req0_valid = 1'b1; req0_data = 128'hffeeddccbbaa99887766554433221100;
    cycle();
    req0_valid = 1'b0;
    repeat (2) cycle();
    release_one();
    repeat (3) cycle();

    // both requesters continuously: alternating grants
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_data = rnd128(); req1_data = rnd128();
      cycle();
    end
    drain_all();

    // fill to the in-flight limit with results stalled
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req0_data = rnd128(); req1_data = rnd128();
      cycle();
    end
    release_one();
    repeat (5) cycle();
    drain_all();

    // reload with three blocks outstanding
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin req0_data = rnd128(); cycle(); end
    req0_valid = 1'b0;
    cycle();
    pulse_load();
    cycle();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (4) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin release_one(); cycle(); end
    repeat (15) cycle();

    // result with nothing outstanding
    drain_all();
    core_out_en = 1'b1; core_out_data = rnd128();
    repeat (3) cycle();

    // kill in the middle of a key load
    pulse_load();
    cycle();
    for (int i = 0; i < 20; i++) begin
      if (m_mode == MD_LOAD && m_step == 5) break;
      cycle();
    end
    kill = 1'b1;
    cycle();
    kill = 1'b0;
    repeat (3) cycle();
    pulse_load();
    repeat (15) cycle();

    // randomized traffic with occasional reloads and kills
    rel_pct = 45;
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(2) == 0);
      req0_data = rnd128();
      req1_data = rnd128();
      kill = ($urandom_range(499) == 0);
      if (!kill && (m_mode == MD_NOKEY || $urandom_range(149) == 0)) pulse_load();
      if ($urandom_range(299) == 0) begin core_out_en = 1'b1; core_out_data = rnd128(); end
      cycle();
    end
    kill = 1'b0;
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_128_sched.md
Name: aes_128_sched

Overview:
- Controller in front of aes_128_top.
- Loads the 11 round keys from an external key store into the core through en_wr/key_round_wr.
- Round-robin arbitrates two block requesters onto the single core input (in_en/in_data).
- Tags every issued block and returns the core's in-order results to the originating requester.
- Throttles issue to a bounded in-flight count, and drains the core before any key reload.

Parameters:
- MAX_INFLIGHT, 16: maximum blocks issued to the core without a result; also the tag FIFO depth (power of 2).
- ISSUE_GAP, 1: minimum cycles between consecutive core_in_en pulses (1 = back-to-back).

Ports:
- clk  in  1: system clock.
- kill  in  1: reset, synchronous, active-high.
- key_load_start  in  1: pulse requesting a round-key (re)load.
- key_rd_addr  out  4: key store read address, round 0..10.
- key_rd_data  in  128: key store data, valid one cycle after key_rd_addr.
- key_valid  out  1: round keys loaded; requests may be granted.
- req0_valid  in  1: requester 0 has a block.
- req0_data  in  128: requester 0 plaintext.
- req0_ready  out  1: requester 0 transfer accepted this cycle.
- req1_valid  in  1: requester 1 has a block.
- req1_data  in  128: requester 1 plaintext.
- req1_ready  out  1: requester 1 transfer accepted this cycle.
- en_wr  out  1: round-key write strobe to the core.
- key_round_wr  out  128: round key to the core.
- core_in_en  out  1: block strobe to the core.
- core_in_data  out  128: block to the core.
- core_out_en  in  1: core result strobe.
- core_out_data  in  128: core result.
- rsp_valid  out  1: result strobe to the requesters.
- rsp_id  out  1: requester that owns the result.
- rsp_data  out  128: ciphertext.
- busy  out  1: state is not RUN, or inflight != 0.
- err_pulse  out  1: core_out_en arrived while the tag FIFO was empty.

Behaviour:
- Reset (kill=1, sampled at posedge clk): state=NOKEY; inflight=0; tag FIFO empty; RR pointer favours requester 0; gap counter=0.
- Outputs during reset: all outputs 0, key_rd_addr=0.
- kill mid-operation aborts a key load or any in-flight tracking immediately; results arriving later count as errors (err_pulse).
- States: NOKEY, LOAD, RUN, DRAIN.
  - NOKEY: key_load_start -> LOAD.
  - RUN: key_load_start with inflight=0 -> LOAD; with inflight!=0 -> DRAIN.
  - DRAIN: no grants; inflight reaches 0 -> LOAD.
  - key_load_start in LOAD or DRAIN is ignored.
- LOAD sequence:
  - key_rd_addr steps 0..10 on consecutive cycles, starting the first LOAD cycle.
  - en_wr=1 with key_round_wr=key_rd_data one cycle after each address: 11 consecutive en_wr cycles, rounds in ascending order.
  - key_valid drops on LOAD entry and rises the cycle after the last en_wr, together with the transition to RUN.
- Grant (RUN only): eligible = key_valid and inflight < MAX_INFLIGHT and gap counter = 0.
  - reqN_ready is combinational: eligible, reqN_valid, and the RR choice.
  - Only one reqN_ready may be high per cycle.
  - With both valid, the requester not granted last wins; the pointer updates on each transfer.
- Issue timing: core_in_en=1 and core_in_data = registered req data exactly one cycle after a transfer (valid & ready).
- After an issue, the gap counter loads ISSUE_GAP-1; the next grant is allowed once it is 0.
- In-flight accounting:
  - Transfer: inflight+1 and the requester id is pushed into the tag FIFO.
  - core_out_en: inflight-1 and the FIFO is popped.
  - Both in one cycle: count unchanged, push and pop both performed.
- Response path:
  - rsp_valid, rsp_id (popped tag) and rsp_data (registered core_out_data) follow core_out_en by one cycle.
  - No backpressure: requesters must sink every rsp_valid.
- Error case: core_out_en with the FIFO empty gives err_pulse=1 for one cycle, rsp_valid=0, and inflight stays 0 (no underflow).
- Full case: at inflight=MAX_INFLIGHT both readys are 0. A simultaneous core_out_en does not re-enable a grant until the next cycle.

Test Plan:
- kill for 30 cycles, then key_load_start; key store holds round r = {16{8'(r)}} -> key_rd_addr 0..10, en_wr high 11 cycles with matching keys, key_valid high the cycle after; busy 0 after.
- Only req0_valid, data 128'hffeeddccbbaa99887766554433221100 -> req0_ready same cycle, core_in_en next cycle with that data; model core result -> rsp_valid one cycle after core_out_en, rsp_id=0.
- Both requesters valid continuously for 8 cycles, ISSUE_GAP=1 -> grants alternate 0,1,0,1...; rsp_id sequence matches issue order.
- Stall core results; issue 16 blocks -> readys held 0 at inflight=16; one core_out_en -> exactly one further grant, starting the following cycle.
- key_load_start with 3 in flight -> state DRAIN, no grants; after 3 core_out_en -> LOAD, 11 en_wr, then RUN.
- core_out_en with nothing in flight -> err_pulse one cycle, rsp_valid 0; assert kill during LOAD at round 5 -> en_wr 0 next cycle, key_valid 0, state NOKEY.
